// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the operand source and alu_seq.
//   master: drives valid_in, A, B, sel_alu; observes ready and the result side.
//   slave : the ALU; consumes the request, drives ready, valid_out, RES, RES_HI,
//           Z, N, C, V, err.
interface alu_seq_if #(
  parameter int unsigned ANCHO = 8
);
  logic             valid_in;
  logic [ANCHO-1:0] A;
  logic [ANCHO-1:0] B;
  logic [3:0]       sel_alu;
  logic             ready;
  logic             valid_out;
  logic [ANCHO-1:0] RES;
  logic [ANCHO-1:0] RES_HI;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;
  logic             err;

  modport master (
    output valid_in, A, B, sel_alu,
    input  ready, valid_out, RES, RES_HI, Z, N, C, V, err
  );

  modport slave (
    input  valid_in, A, B, sel_alu,
    output ready, valid_out, RES, RES_HI, Z, N, C, V, err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with status flags and a valid/ready handshake.
// Single-cycle ops complete on the accepting edge; MUL runs an ANCHO-step
// shift-add and blocks new requests until it completes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_seq_if.slave (request in, result/flags out)
module alu_seq #(
  parameter int unsigned ANCHO = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);
  localparam int unsigned W  = ANCHO;
  localparam int unsigned CW = $clog2(ANCHO + 1);
  localparam logic [W-1:0]  W_VAL    = W'(ANCHO);
  localparam logic [CW-1:0] CNT_LAST = CW'(ANCHO - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t         state_q, state_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   res_q, res_d, res_hi_q, res_hi_d;
  logic           z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;
  logic [W-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           accept_c;
  logic [W:0]     add_c, sub_c, mul_sum_c;
  logic           big_shift_c;
  logic [W-1:0]   rot_c;
  logic [W-1:0]   alu_res_c, prod_lo_c, prod_hi_c;
  logic           alu_z_c, alu_n_c, alu_c_c, alu_v_c, alu_err_c, alu_wr_c;

  assign accept_c    = bus.valid_in && ready_q;
  assign add_c       = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_c       = {1'b0, bus.A} - {1'b0, bus.B};
  assign big_shift_c = (bus.B >= W_VAL);
  assign rot_c       = bus.B % W_VAL;

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift {acc, mplier} right; after W steps it holds the product.
  assign mul_sum_c = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_hi_c = mul_sum_c[W:1];
  assign prod_lo_c = {mul_sum_c[0], mplier_q[W-1:1]};

  // Single-cycle datapath; alu_wr_c=0 means RES/RES_HI are left untouched.
  always_comb begin
    alu_res_c = '0;
    alu_c_c   = 1'b0;
    alu_v_c   = 1'b0;
    alu_err_c = 1'b0;
    alu_wr_c  = 1'b1;
    case (bus.sel_alu)
      OP_ADD: begin
        alu_res_c = add_c[W-1:0];
        alu_c_c   = add_c[W];
        alu_v_c   = (bus.A[W-1] == bus.B[W-1]) && (add_c[W-1] != bus.A[W-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res_c = sub_c[W-1:0];
        alu_c_c   = sub_c[W];
        alu_v_c   = (bus.A[W-1] != bus.B[W-1]) && (sub_c[W-1] != bus.A[W-1]);
        alu_wr_c  = (bus.sel_alu == OP_SUB);
      end
      OP_AND: alu_res_c = bus.A & bus.B;
      OP_OR:  alu_res_c = bus.A | bus.B;
      OP_XOR: alu_res_c = bus.A ^ bus.B;
      OP_SLL: alu_res_c = big_shift_c ? '0 : (bus.A << bus.B);
      OP_SRL: alu_res_c = big_shift_c ? '0 : (bus.A >> bus.B);
      OP_SRA: alu_res_c = big_shift_c ? {W{bus.A[W-1]}}
                                      : $unsigned($signed(bus.A) >>> bus.B);
      // A shift by W yields 0, so rot_c==0 reduces to A on both rotates.
      OP_ROL: alu_res_c = (bus.A << rot_c) | (bus.A >> (W_VAL - rot_c));
      OP_ROR: alu_res_c = (bus.A >> rot_c) | (bus.A << (W_VAL - rot_c));
      OP_MUL: alu_res_c = '0;
      default: alu_err_c = 1'b1;
    endcase
    alu_z_c = !alu_err_c && (alu_res_c == '0);
    alu_n_c = !alu_err_c && alu_res_c[W-1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_c && bus.sel_alu == OP_MUL) state_d = S_MUL;
      S_MUL:  if (cnt_q == CNT_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; everything holds unless written.
  always_comb begin
    ready_d  = (state_d == S_IDLE);
    valid_d  = 1'b0;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    err_d    = err_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (bus.sel_alu == OP_MUL) begin
            mcand_d  = bus.A;
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            valid_d = 1'b1;
            if (alu_wr_c) begin
              res_d    = alu_res_c;
              res_hi_d = '0;
            end
            z_d   = alu_z_c;
            n_d   = alu_n_c;
            c_d   = alu_c_c;
            v_d   = alu_v_c;
            err_d = alu_err_c;
          end
        end
      end
      S_MUL: begin
        acc_d    = prod_hi_c;
        mplier_d = prod_lo_c;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          valid_d  = 1'b1;
          res_d    = prod_lo_c;
          res_hi_d = prod_hi_c;
          z_d      = (prod_lo_c == '0);
          n_d      = prod_lo_c[W-1];
          c_d      = (prod_hi_c != '0);
          v_d      = 1'b0;
          err_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output and multiply registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.valid_out = valid_q;
  assign bus.RES       = res_q;
  assign bus.RES_HI    = res_hi_q;
  assign bus.Z         = z_q;
  assign bus.N         = n_q;
  assign bus.C         = c_q;
  assign bus.V         = v_q;
  assign bus.err       = err_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the lab's combinational ALU. It keeps the eight base operations and adds rotates, compare and an iterative unsigned multiply. It also adds a status-flag set and a valid/ready handshake. It sits between the operand register file and the result/display stage, and accepts one operation per cycle except multiply, which blocks the unit for ANCHO cycles.

## Interface
- ANCHO, 8, operand and result width in bits (≥ 2).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  operation request; accepted on a rising edge when valid_in && ready.
- A  input  ANCHO  operand A (unsigned, or two's complement where stated).
- B  input  ANCHO  operand B or shift/rotate amount.
- sel_alu  input  4  operation select (see Operation).
- ready  output  1  high when a new request can be accepted.
- valid_out  output  1  one-cycle pulse; RES/RES_HI/flags/err updated and valid.
- RES  output  ANCHO  result (low half for multiply).
- RES_HI  output  ANCHO  multiply high half; 0 for all other ops.
- Z, N, C, V  output  1 each  zero, negative, carry/borrow, signed overflow.
- err  output  1  illegal sel_alu code on the last completed operation.

## Operation
- Operands and sel_alu are captured on acceptance. Input changes after that are ignored until completion.
- Op codes and results:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: A<<B.
  - 6 SRL: logical right shift.
  - 7 SRA: arithmetic right shift; sign of A[ANCHO-1] fills.
  - 8 ROL and 9 ROR: rotate by B mod ANCHO.
  - 10 CMP: computes A−B, updates flags only; RES/RES_HI keep previous values.
  - 11 MUL: unsigned A×B, 2·ANCHO-bit product split into {RES_HI,RES}.
  - 12–15: illegal.
- Shift rules: for SLL/SRL with B ≥ ANCHO, the result is 0. For SRA with B ≥ ANCHO, the result is all copies of A's sign bit.
- Results are truncated to ANCHO bits.
- Flags are written on every completion:
  - Z = (RES==0); for CMP, Z = (A−B==0).
  - N = MSB of the result (or of A−B for CMP).
  - C: ADD gives the carry out of bit ANCHO-1. SUB/CMP give the borrow (1 iff A<B unsigned). MUL gives 1 iff RES_HI≠0. C=0 for all other ops.
  - V: ADD/SUB/CMP give signed two's-complement overflow; V=0 for all other ops.
- Illegal code: RES=0, RES_HI=0, Z=N=C=V=0, err=1, with single-cycle timing. err=0 on every legal completion.
- State machine:
  - IDLE: ready=1. Accepting a non-MUL op computes it and returns its result at that edge; the FSM stays in IDLE. Accepting MUL loads the multiplicand, the multiplier and a zero accumulator, sets count=0, and moves to MUL.
  - MUL: ready=0. Each edge performs one shift-add step and count++. On the edge where count reaches ANCHO, RES/RES_HI/flags are written, valid_out is pulsed, and the FSM returns to IDLE.
- valid_in while ready=0 is ignored: not queued, no error.

## Timing
- Reset (asynchronous, on rst_n low): RES=0, RES_HI=0, Z=N=C=V=0, err=0, valid_out=0, ready=1, FSM=IDLE, internal multiply registers cleared.
- Non-MUL latency: accept at edge k, then outputs are valid and valid_out=1 during cycle k→k+1. Back-to-back accepts give valid_out high continuously, throughput 1 op/cycle.
- MUL latency: accept at edge k.
  - ready=0 from edge k to edge k+ANCHO.
  - Result and valid_out=1 after edge k+ANCHO.
  - ready=1 again in that same cycle, so a new request can be accepted at edge k+ANCHO+1.
- valid_out is deasserted on the edge after its pulse unless another completion occurs on that edge.
- Outputs hold their last values between completions.
- Reset asserted mid-MUL aborts the operation: no valid_out, and outputs take reset values immediately.
- Simultaneous valid_in and MUL completion: valid_in is ignored on that edge, because ready was 0 before the edge.

## Test plan
- ANCHO=8, ADD A=0xFF B=0x01 → RES=0x00, Z=1, C=1, V=0, valid_out one cycle after accept.
- SUB A=0x80 B=0x01 → RES=0x7F, V=1, C=0, N=0; then CMP A=0x03 B=0x05 → RES unchanged, C=1, N=1, Z=0.
- SRA A=0x90 B=2 → RES=0xE4. SRA A=0x90 B=9 → RES=0xFF. SLL A=0x01 B=8 → RES=0x00. ROR A=0x01 B=9 → RES=0x80.
- MUL A=0xFF B=0xFF → ready low for 8 cycles, then RES=0x01, RES_HI=0xFE, C=1. A/B changed and valid_in held high during the busy period → the result is unaffected and no extra completion occurs.
- sel_alu=13 → RES=0, RES_HI=0, all flags 0, err=1; next legal op → err=0.
- rst_n pulsed low at cycle 4 of a MUL → outputs go to reset values immediately, ready=1, and no valid_out is seen. A fresh ADD after release completes normally.
